pixel_stream_writer: RTL and testbench

PIXEL_STREAM_WRITER -- requirements
Module: pixel_stream_writer

---
 rtl/pixel_stream_writer.sv | 209 ++++++++++++++++++++
 tb/tb_pixel_stream_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_writer.sv
// pixel_stream_writer
//    Accepts a valid/ready pixel stream framed by SOF/EOL markers and turns it
//    into linear frame-buffer writes (address = y*H_RES + x).
//    Malformed framing (short, overlong or restarted lines) sets a sticky error.
//
// Ports
//    iCLK, iRST                  clock, asynchronous active-high reset
//    iPIX_VALID/DATA/SOF/EOL     source pixel stream
//    oPIX_READY                  sink ready (transfer = iPIX_VALID & oPIX_READY)
//    iFREEZE                     blocks the start of a new frame while idle
//    oWR_EN/ADDR/DATA            registered frame-buffer write port
//    oFRAME_DONE                 one-cycle pulse, aligned with the last write
//    oFRAME_CNT                  completed frames, wraps 255 -> 0
//    oERR                        sticky framing error, cleared by reset only
module pixel_stream_writer #(
   parameter int H_RES = 320,
   parameter int V_RES = 240
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iPIX_VALID,
   input  logic [23:0] iPIX_DATA,
   input  logic        iPIX_SOF,
   input  logic        iPIX_EOL,
   output logic        oPIX_READY,
   input  logic        iFREEZE,
   output logic [16:0] oWR_ADDR,
   output logic [23:0] oWR_DATA,
   output logic        oWR_EN,
   output logic        oFRAME_DONE,
   output logic [7:0]  oFRAME_CNT,
   output logic        oERR
);

   localparam logic [8:0]  LINE_LEN  = 9'(H_RES);
   localparam logic [16:0] LINE_STEP = 17'(H_RES);
   localparam logic [7:0]  LAST_LINE = 8'(V_RES - 1);

   typedef enum logic [0:0] {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } state_t;

   state_t      state_r, stateNext_s;
   logic [8:0]  x_r, xNext_s;
   logic [7:0]  y_r, yNext_s;
   logic [16:0] base_r, baseNext_s;

   logic        ready_s;
   logic        xfer_s;
   logic        accept_s;
   logic        wrEn_s;
   logic [16:0] wrAddr_s;
   logic        errSet_s;
   logic        done_s;
   logic [8:0]  effX_s;
   logic [8:0]  postX_s;
   logic [7:0]  effY_s;
   logic [16:0] effBase_s;

   logic        wrEn_r;
   logic [16:0] wrAddr_r;
   logic [23:0] wrData_r;
   logic        frameDone_r;
   logic [7:0]  frameCnt_r;
   logic        err_r;

   // Ready: forced low in reset, always high mid-frame, gated by freeze while idle
   always_comb begin
      if (iRST) begin
         ready_s = 1'b0;
      end else if (state_r == ACTIVE) begin
         ready_s = 1'b1;
      end else begin
         ready_s = ~iFREEZE;
      end
   end

   assign xfer_s = iPIX_VALID & ready_s;

   // Next-state / write decode; SOF first rewinds the position, then the
   // pixel is placed, then EOL advances to the next line
   always_comb begin
      stateNext_s = state_r;
      xNext_s     = x_r;
      yNext_s     = y_r;
      baseNext_s  = base_r;
      accept_s    = 1'b0;
      wrEn_s      = 1'b0;
      wrAddr_s    = 17'd0;
      errSet_s    = 1'b0;
      done_s      = 1'b0;
      effX_s      = x_r;
      effY_s      = y_r;
      effBase_s   = base_r;
      postX_s     = x_r;

      if (xfer_s) begin
         if (iPIX_SOF) begin
            // SOF while a frame is in progress abandons that frame
            accept_s  = 1'b1;
            effX_s    = 9'd0;
            effY_s    = 8'd0;
            effBase_s = 17'd0;
            errSet_s  = (state_r == ACTIVE);
         end else if (state_r == ACTIVE) begin
            accept_s = 1'b1;
         end else begin
            accept_s = 1'b0;
         end
      end else begin
         accept_s = 1'b0;
      end

      if (accept_s) begin
         if (effX_s < LINE_LEN) begin
            wrEn_s   = 1'b1;
            wrAddr_s = effBase_s + {8'd0, effX_s};
            postX_s  = effX_s + 9'd1;
         end else begin
            // overlong line: drop the pixel and hold x at the line length
            errSet_s = 1'b1;
            postX_s  = effX_s;
         end

         if (iPIX_EOL) begin
            errSet_s = errSet_s | (postX_s != LINE_LEN);
            if (effY_s == LAST_LINE) begin
               done_s      = 1'b1;
               stateNext_s = WAIT_SOF;
               xNext_s     = 9'd0;
               yNext_s     = 8'd0;
               baseNext_s  = 17'd0;
            end else begin
               stateNext_s = ACTIVE;
               xNext_s     = 9'd0;
               yNext_s     = effY_s + 8'd1;
               baseNext_s  = effBase_s + LINE_STEP;
            end
         end else begin
            stateNext_s = ACTIVE;
            xNext_s     = postX_s;
            yNext_s     = effY_s;
            baseNext_s  = effBase_s;
         end
      end else begin
         stateNext_s = state_r;
      end
   end

   // Position and state registers
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_r <= WAIT_SOF;
         x_r     <= 9'd0;
         y_r     <= 8'd0;
         base_r  <= 17'd0;
      end else begin
         state_r <= stateNext_s;
         x_r     <= xNext_s;
         y_r     <= yNext_s;
         base_r  <= baseNext_s;
      end
   end

   // Registered write port; address/data hold between writes
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         wrEn_r   <= 1'b0;
         wrAddr_r <= 17'd0;
         wrData_r <= 24'd0;
      end else begin
         wrEn_r <= wrEn_s;
         if (wrEn_s) begin
            wrAddr_r <= wrAddr_s;
            wrData_r <= iPIX_DATA;
         end else begin
            wrAddr_r <= wrAddr_r;
            wrData_r <= wrData_r;
         end
      end
   end

   // Frame completion pulse, frame counter and sticky error flag
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         frameDone_r <= 1'b0;
         frameCnt_r  <= 8'd0;
         err_r       <= 1'b0;
      end else begin
         frameDone_r <= done_s;
         if (done_s) begin
            frameCnt_r <= frameCnt_r + 8'd1;
         end else begin
            frameCnt_r <= frameCnt_r;
         end
         err_r <= err_r | errSet_s;
      end
   end

   assign oPIX_READY  = ready_s;
   assign oWR_EN      = wrEn_r;
   assign oWR_ADDR    = wrAddr_r;
   assign oWR_DATA    = wrData_r;
   assign oFRAME_DONE = frameDone_r;
   assign oFRAME_CNT  = frameCnt_r;
   assign oERR        = err_r;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// tb_pixel_stream_writer
//    Directed bench for pixel_stream_writer with default 320x240 geometry.
//    Inputs change on the falling edge; registered outputs are read on the
//    following falling edge, i.e. one cycle after the transfer.
module tb_pixel_stream_writer;

   logic        iCLK;
   logic        iRST;
   logic        iPIX_VALID;
   logic [23:0] iPIX_DATA;
   logic        iPIX_SOF;
   logic        iPIX_EOL;
   logic        oPIX_READY;
   logic        iFREEZE;
   logic [16:0] oWR_ADDR;
   logic [23:0] oWR_DATA;
   logic        oWR_EN;
   logic        oFRAME_DONE;
   logic [7:0]  oFRAME_CNT;
   logic        oERR;

   int testsRun    = 0;
   int testsFailed = 0;

   pixel_stream_writer #(.H_RES(320), .V_RES(240)) dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iPIX_VALID  (iPIX_VALID),
      .iPIX_DATA   (iPIX_DATA),
      .iPIX_SOF    (iPIX_SOF),
      .iPIX_EOL    (iPIX_EOL),
      .oPIX_READY  (oPIX_READY),
      .iFREEZE     (iFREEZE),
      .oWR_ADDR    (oWR_ADDR),
      .oWR_DATA    (oWR_DATA),
      .oWR_EN      (oWR_EN),
      .oFRAME_DONE (oFRAME_DONE),
      .oFRAME_CNT  (oFRAME_CNT),
      .oERR        (oERR)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   function automatic logic [23:0] pd(input int a);
      logic [23:0] k;
      k = 24'hA53C96;
      return 24'(a) ^ k;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chkWr(input string tag, input logic en, input int addr);
      chk({tag, "_en"}, {31'd0, oWR_EN}, {31'd0, en});
      if (en) begin
         chk({tag, "_addr"}, {15'd0, oWR_ADDR}, addr);
      end
   endtask

   // one clock of stimulus; returns on the next falling edge
   task automatic step(input logic v, input logic [23:0] d, input logic s, input logic e);
      iPIX_VALID = v;
      iPIX_DATA  = d;
      iPIX_SOF   = s;
      iPIX_EOL   = e;
      @(negedge iCLK);
      iPIX_VALID = 1'b0;
      iPIX_SOF   = 1'b0;
      iPIX_EOL   = 1'b0;
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, "_en"},    {31'd0, oWR_EN},      32'd0);
      chk({tag, "_addr"},  {15'd0, oWR_ADDR},    32'd0);
      chk({tag, "_data"},  {8'd0, oWR_DATA},     32'd0);
      chk({tag, "_done"},  {31'd0, oFRAME_DONE}, 32'd0);
      chk({tag, "_cnt"},   {24'd0, oFRAME_CNT},  32'd0);
      chk({tag, "_err"},   {31'd0, oERR},        32'd0);
      chk({tag, "_ready"}, {31'd0, oPIX_READY},  32'd0);
   endtask

   // asserted on a falling edge and checked before any clock edge
   task automatic pulseReset(input string tag);
      iRST = 1'b1;
      #1;
      chkAllZero(tag);
      @(negedge iCLK);
      iRST = 1'b0;
   endtask

   initial begin
      iRST       = 1'b1;
      iPIX_VALID = 1'b0;
      iPIX_DATA  = 24'd0;
      iPIX_SOF   = 1'b0;
      iPIX_EOL   = 1'b0;
      iFREEZE    = 1'b0;
      @(negedge iCLK);
      @(negedge iCLK);
      chkAllZero("reset");
      iRST = 1'b0;
      #1;
      chk("idle_ready", {31'd0, oPIX_READY}, 32'd1);

      // full 320x240 frame
      for (int y = 0; y < 240; y++) begin
         for (int x = 0; x < 320; x++) begin
            step(1'b1, pd(y * 320 + x), (x == 0) && (y == 0), x == 319);
            chk("ff_en",   {31'd0, oWR_EN},      32'd1);
            chk("ff_addr", {15'd0, oWR_ADDR},    y * 320 + x);
            chk("ff_data", {8'd0, oWR_DATA},     {8'd0, pd(y * 320 + x)});
            chk("ff_done", {31'd0, oFRAME_DONE}, {31'd0, (x == 319) && (y == 239)});
         end
      end
      chk("ff_cnt", {24'd0, oFRAME_CNT}, 32'd1);
      chk("ff_err", {31'd0, oERR},       32'd0);
      step(1'b0, 24'd0, 1'b0, 1'b0);
      chkWr("ff_idle", 1'b0, 0);
      chk("ff_done_low", {31'd0, oFRAME_DONE}, 32'd0);

      // garbage before SOF is dropped
      for (int i = 0; i < 5; i++) begin
         step(1'b1, pd(1000 + i), 1'b0, 1'b0);
         chkWr("presof", 1'b0, 0);
      end
      step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
      chkWr("sof", 1'b1, 0);
      chk("sof_data", {8'd0, oWR_DATA}, 32'h00ABCDEF);
      chk("sof_err",  {31'd0, oERR},    32'd0);

      // short line: EOL on the 300th pixel of line 0
      for (int x = 1; x < 300; x++) begin
         step(1'b1, pd(x), 1'b0, x == 299);
         chkWr("short", 1'b1, x);
         if (x == 298) begin
            chk("short_err_pre", {31'd0, oERR}, 32'd0);
         end
      end
      chk("short_err", {31'd0, oERR}, 32'd1);
      step(1'b1, pd(7), 1'b0, 1'b0);
      chkWr("short_next", 1'b1, 320);

      // long line: 325 pixels before EOL
      pulseReset("rst_long");
      step(1'b1, pd(0), 1'b1, 1'b0);
      chkWr("long0", 1'b1, 0);
      for (int x = 1; x < 325; x++) begin
         step(1'b1, pd(x), 1'b0, x == 324);
         chkWr("long", x < 320, x);
         if (x == 319) begin
            chk("long_err_pre", {31'd0, oERR}, 32'd0);
         end
         if (x == 320) begin
            chk("long_err", {31'd0, oERR}, 32'd1);
         end
      end
      step(1'b1, pd(9), 1'b0, 1'b0);
      chkWr("long_next", 1'b1, 320);

      // SOF in the middle of line 10
      pulseReset("rst_mid");
      for (int y = 0; y < 10; y++) begin
         for (int x = 0; x < 320; x++) begin
            step(1'b1, pd(x), (x == 0) && (y == 0), x == 319);
            chkWr("mid", 1'b1, y * 320 + x);
         end
      end
      for (int x = 0; x < 5; x++) begin
         step(1'b1, pd(x), 1'b0, 1'b0);
         chkWr("mid_l10", 1'b1, 3200 + x);
      end
      chk("mid_err_pre", {31'd0, oERR}, 32'd0);
      step(1'b1, 24'h0F1E2D, 1'b1, 1'b0);
      chkWr("mid_sof", 1'b1, 0);
      chk("mid_sof_data", {8'd0, oWR_DATA},     32'h000F1E2D);
      chk("mid_sof_err",  {31'd0, oERR},        32'd1);
      chk("mid_sof_done", {31'd0, oFRAME_DONE}, 32'd0);
      step(1'b1, pd(1), 1'b0, 1'b0);
      chkWr("mid_next", 1'b1, 1);

      // freeze is ignored mid-frame
      iFREEZE = 1'b1;
      #1;
      chk("frz_active_ready", {31'd0, oPIX_READY}, 32'd1);
      step(1'b1, pd(2), 1'b0, 1'b0);
      chkWr("frz_active", 1'b1, 2);

      // reset mid-frame, then freeze holds off the new frame
      pulseReset("rst_frz");
      #1;
      chk("frz_ready", {31'd0, oPIX_READY}, 32'd0);
      step(1'b1, pd(3), 1'b1, 1'b0);
      chkWr("frz_sof", 1'b0, 0);
      step(1'b1, pd(4), 1'b0, 1'b0);
      chkWr("frz_pix", 1'b0, 0);
      iFREEZE = 1'b0;
      #1;
      chk("unfrz_ready", {31'd0, oPIX_READY}, 32'd1);
      step(1'b1, pd(5), 1'b0, 1'b0);
      chkWr("unfrz_nosof", 1'b0, 0);
      step(1'b1, 24'h123456, 1'b1, 1'b0);
      chkWr("unfrz_sof", 1'b1, 0);
      chk("unfrz_data", {8'd0, oWR_DATA}, 32'h00123456);
      step(1'b0, pd(6), 1'b0, 1'b0);
      chkWr("gap", 1'b0, 0);
      step(1'b1, pd(7), 1'b0, 1'b0);
      chkWr("after_gap", 1'b1, 1);
      chk("after_gap_err", {31'd0, oERR}, 32'd0);

      // SOF and EOL on the same pixel
      step(1'b1, pd(8), 1'b1, 1'b1);
      chkWr("soleol", 1'b1, 0);
      chk("soleol_err",  {31'd0, oERR},        32'd1);
      chk("soleol_done", {31'd0, oFRAME_DONE}, 32'd0);
      step(1'b1, pd(9), 1'b0, 1'b0);
      chkWr("soleol_next", 1'b1, 320);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
